scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_if.sv | 31 +++
 rtl/scan_decoder.sv | 121 ++++++++++++
 tb/tb_scan_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder_if
// Description : Control/select bundle between a scan_decoder and its driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_decoder_if #(
    parameter int ADDR_W = 2
);
    localparam int OUT_W = 2 ** ADDR_W;

    logic              enable;
    logic              start;
    logic              scan;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  sel;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;

    modport master (
        output enable, start, scan, addr,
        input  sel, cur_addr, busy, done
    );

    modport slave (
        input  enable, start, scan, addr,
        output sel, cur_addr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Registered one-hot/thermometer address decoder with an
//               auto-increment scan mode.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int ADDR_W = 2,
    parameter int THERMO = 0
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    scan_decoder_if.slave bus
);
    localparam int OUT_W = 2 ** ADDR_W;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_direct = 2'd1;
    localparam logic [1:0] c_st_scan   = 2'd2;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(OUT_W - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [OUT_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_show;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_go;
    logic [OUT_W-1:0]  w_dec;

    // Decode the address that will be held after the edge, so sel is
    // registered together with cur_addr.
    genvar k;
    generate
        for (k = 0; k < OUT_W; k++) begin : g_dec
            localparam logic [ADDR_W-1:0] c_k = ADDR_W'(k);
            if (THERMO != 0) begin : g_thermo
                assign w_dec[k] = (c_k <= w_addr_nxt);
            end else begin : g_onehot
                assign w_dec[k] = (c_k == w_addr_nxt);
            end
        end
    endgenerate

    always_comb begin
        w_go        = bus.enable & bus.start;
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_show      = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_st_idle, c_st_direct: begin
                if (w_go) begin
                    w_addr_nxt = bus.addr;
                    w_show     = 1'b1;
                    if (bus.scan) begin
                        w_state_nxt = c_st_scan;
                        w_busy_nxt  = 1'b1;
                        w_done_nxt  = (bus.addr == c_last_addr);
                    end else begin
                        w_state_nxt = c_st_direct;
                    end
                end else if (r_state == c_st_direct) begin
                    if (bus.enable) begin
                        w_show = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_scan: begin
                // Start requests are ignored here; enable low only pauses.
                w_busy_nxt = 1'b1;
                if (bus.enable) begin
                    if (r_cur_addr == c_last_addr) begin
                        w_state_nxt = c_st_idle;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_addr_nxt = r_cur_addr + ADDR_W'(1);
                        w_show     = 1'b1;
                        w_done_nxt = (w_addr_nxt == c_last_addr);
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_cur_addr <= '0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_addr_nxt;
            r_sel      <= w_show ? w_dec : '0;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.sel      = r_sel;
    assign bus.cur_addr = r_cur_addr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_decoder
// Description : Three decoder configurations driven in lockstep and compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    scan_decoder_if #(.ADDR_W(2)) bus_a ();
    scan_decoder_if #(.ADDR_W(2)) bus_t ();
    scan_decoder_if #(.ADDR_W(3)) bus_w ();

    scan_decoder #(.ADDR_W(2), .THERMO(0)) u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    scan_decoder #(.ADDR_W(2), .THERMO(1)) u_t (.clk(clk), .reset_n(reset_n), .bus(bus_t));
    scan_decoder #(.ADDR_W(3), .THERMO(0)) u_w (.clk(clk), .reset_n(reset_n), .bus(bus_w));

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    bit       in_en, in_st, in_sc;
    logic [2:0] in_a;

    // Model: 0 = idle, 1 = direct, 2 = scanning
    int          m_mode [3] = '{0, 0, 0};
    int          m_cur  [3] = '{0, 0, 0};
    logic [63:0] m_sel  [3] = '{0, 0, 0};
    bit          m_busy [3] = '{0, 0, 0};
    bit          m_done [3] = '{0, 0, 0};
    int          c_lastv [3] = '{3, 3, 7};
    bit          c_th    [3] = '{0, 1, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] dec(input int a, input bit th);
        logic [63:0] one = 64'd1;
        return th ? ((one << (a + 1)) - one) : (one << a);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_mode[i] = 0; m_cur[i] = 0; m_sel[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int a;
                a = int'(in_a) & c_lastv[i];
                m_done[i] = 0;
                if (m_mode[i] == 2) begin
                    if (in_en) begin
                        if (m_cur[i] == c_lastv[i]) begin
                            m_mode[i] = 0;
                            m_sel[i]  = 0;
                        end else begin
                            m_cur[i]  = m_cur[i] + 1;
                            m_sel[i]  = dec(m_cur[i], c_th[i]);
                            m_done[i] = (m_cur[i] == c_lastv[i]);
                        end
                    end else begin
                        m_sel[i] = 0;
                    end
                end else if (in_en && in_st) begin
                    m_cur[i]  = a;
                    m_mode[i] = in_sc ? 2 : 1;
                    m_sel[i]  = dec(a, c_th[i]);
                    m_done[i] = in_sc && (a == c_lastv[i]);
                end else if (!in_en || m_mode[i] == 0) begin
                    m_mode[i] = 0;
                    m_sel[i]  = 0;
                end
                m_busy[i] = (m_mode[i] == 2);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("a_sel",  64'(bus_a.sel),      m_sel[0]);
            chk("a_cur",  64'(bus_a.cur_addr), 64'(m_cur[0]));
            chk("a_busy", 64'(bus_a.busy),     64'(m_busy[0]));
            chk("a_done", 64'(bus_a.done),     64'(m_done[0]));
            chk("t_sel",  64'(bus_t.sel),      m_sel[1]);
            chk("t_cur",  64'(bus_t.cur_addr), 64'(m_cur[1]));
            chk("t_busy", 64'(bus_t.busy),     64'(m_busy[1]));
            chk("t_done", 64'(bus_t.done),     64'(m_done[1]));
            chk("w_sel",  64'(bus_w.sel),      m_sel[2]);
            chk("w_cur",  64'(bus_w.cur_addr), 64'(m_cur[2]));
            chk("w_busy", 64'(bus_w.busy),     64'(m_busy[2]));
            chk("w_done", 64'(bus_w.done),     64'(m_done[2]));
        end
    end

    task automatic set_in(input bit en, input bit st, input bit sc, input logic [2:0] a);
        in_en = en; in_st = st; in_sc = sc; in_a = a;
        bus_a.enable = en; bus_a.start = st; bus_a.scan = sc; bus_a.addr = a[1:0];
        bus_t.enable = en; bus_t.start = st; bus_t.scan = sc; bus_t.addr = a[1:0];
        bus_w.enable = en; bus_w.start = st; bus_w.scan = sc; bus_w.addr = a;
    endtask

    task automatic cyc(input bit en, input bit st, input bit sc, input logic [2:0] a);
        @(negedge clk);
        set_in(en, st, sc, a);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input bit check);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 3'd0);
        #2 reset_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_a_sel",  64'(bus_a.sel), 64'd0);
            chk("rst_a_cur",  64'(bus_a.cur_addr), 64'd0);
            chk("rst_a_busy", 64'(bus_a.busy), 64'd0);
            chk("rst_a_done", 64'(bus_a.done), 64'd0);
            chk("rst_w_sel",  64'(bus_w.sel), 64'd0);
        end
        #1 reset_n = 1'b1;
    endtask

    logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exp_th [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_sel",  64'(bus_a.sel), 64'd0);
        chk("reset_cur",  64'(bus_a.cur_addr), 64'd0);
        chk("reset_busy", 64'(bus_a.busy), 64'd0);
        chk("reset_done", 64'(bus_w.done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cmp_on  = 1'b1;

        // Direct decode in both select styles, then enable low clears.
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 0, 3'(k));
            chk("direct_onehot", 64'(bus_a.sel), 64'(exp_oh[k]));
            chk("direct_thermo", 64'(bus_t.sel), 64'(exp_th[k]));
        end
        cyc(0, 0, 0, 3'd0);
        chk("direct_disable", 64'(bus_a.sel), 64'd0);

        // Three-cycle scan from 5 on the 3-bit decoder.
        cyc(1, 1, 1, 3'd5);
        chk("scan5_sel0", 64'(bus_w.sel), 64'h20);
        chk("scan5_done0", 64'(bus_w.done), 64'd0);
        cyc(1, 0, 0, 3'd0);
        chk("scan5_sel1", 64'(bus_w.sel), 64'h40);
        cyc(1, 0, 0, 3'd0);
        chk("scan5_sel2", 64'(bus_w.sel), 64'h80);
        chk("scan5_done2", 64'(bus_w.done), 64'd1);
        cyc(1, 0, 0, 3'd0);
        chk("scan5_busy_after", 64'(bus_w.busy), 64'd0);

        // Pause mid-scan for two cycles.
        cyc(1, 1, 1, 3'd0);
        cyc(1, 0, 0, 3'd0);
        chk("pause_sel1", 64'(bus_a.sel), 64'b0010);
        cyc(0, 0, 0, 3'd0);
        cyc(0, 0, 0, 3'd0);
        chk("pause_sel", 64'(bus_a.sel), 64'd0);
        chk("pause_cur", 64'(bus_a.cur_addr), 64'd1);
        chk("pause_busy", 64'(bus_a.busy), 64'd1);
        cyc(1, 0, 0, 3'd0);
        chk("resume_sel", 64'(bus_a.sel), 64'b0100);
        cyc(1, 0, 0, 3'd0);
        chk("resume_last", 64'(bus_a.sel), 64'b1000);
        chk("resume_done", 64'(bus_a.done), 64'd1);
        cyc(1, 0, 0, 3'd0);

        // Asynchronous reset mid-scan, then start with enable low.
        cyc(1, 1, 1, 3'd1);
        chk("scan1_sel", 64'(bus_a.sel), 64'b0010);
        rst_pulse(1'b1);
        cyc(0, 1, 0, 3'd2);
        chk("start_disabled", 64'(bus_a.sel), 64'd0);

        // One-cycle scan at the last address, and start ignored while scanning.
        cyc(1, 1, 1, 3'd3);
        chk("scan3_sel", 64'(bus_a.sel), 64'b1000);
        chk("scan3_done", 64'(bus_a.done), 64'd1);
        cyc(1, 0, 0, 3'd0);
        chk("scan3_busy_after", 64'(bus_a.busy), 64'd0);
        cyc(1, 1, 1, 3'd0);
        cyc(1, 1, 1, 3'd0);
        chk("restart_ignored", 64'(bus_a.sel), 64'b0010);
        cyc(1, 1, 0, 3'd3);
        chk("restart_ignored2", 64'(bus_a.sel), 64'b0100);
        cyc(1, 0, 0, 3'd0);
        chk("restart_done", 64'(bus_a.done), 64'd1);
        cyc(1, 0, 0, 3'dx);
        cyc(1, 0, 0, 3'dx);
        chk("idle_x_sel", 64'(bus_a.sel), 64'd0);
        chk("idle_x_cur", 64'(bus_a.cur_addr), 64'd3);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if (n % 41 == 40) rst_pulse(1'b0);
        end

        @(negedge clk);
        #1 cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
